// File: rtl/ps2_lcd_stream_pkg.sv
// ps2_pkg: scan-code and LCD constants plus FSM state type shared by the PS/2-to-LCD stream slice.
package ps2_pkg;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [8:0] LCD_NEWLINE = 9'h0C0;
    localparam logic [8:0] LCD_BKSP    = 9'h108;
    localparam logic [8:0] LCD_CUR_L   = 9'h010;
    localparam logic [8:0] LCD_CUR_R   = 9'h014;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} ps2_state_t;

    // Keyboard housekeeping bytes (ack, BAT, echo, resend, errors) never carry key data.
    function automatic logic is_ignored(input logic [7:0] b);
        return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
    endfunction
endpackage

// File: rtl/ps2_lcd_stream_lut.sv
// ps2_lcd_lut: combinational map from a non-extended set-2 make code to a 9-bit LCD code.
module ps2_lcd_lut
    import ps2_pkg::*;
(
    input  logic [7:0] scan_code_i,
    input  logic       letter_upper_i,
    input  logic       symbol_upper_i,
    output logic [8:0] lcd_code_o,
    output logic       mapped_o
);
    logic [4:0]  idx;
    logic [15:0] sym;
    logic [8:0]  cmd;

    always_comb begin
        idx = '0;
        sym = '0;
        cmd = '0;
        case (scan_code_i)
            8'h1C: idx = 5'd1;   8'h32: idx = 5'd2;   8'h21: idx = 5'd3;   8'h23: idx = 5'd4;
            8'h24: idx = 5'd5;   8'h2B: idx = 5'd6;   8'h34: idx = 5'd7;   8'h33: idx = 5'd8;
            8'h43: idx = 5'd9;   8'h3B: idx = 5'd10;  8'h42: idx = 5'd11;  8'h4B: idx = 5'd12;
            8'h3A: idx = 5'd13;  8'h31: idx = 5'd14;  8'h44: idx = 5'd15;  8'h4D: idx = 5'd16;
            8'h15: idx = 5'd17;  8'h2D: idx = 5'd18;  8'h1B: idx = 5'd19;  8'h2C: idx = 5'd20;
            8'h3C: idx = 5'd21;  8'h2A: idx = 5'd22;  8'h1D: idx = 5'd23;  8'h22: idx = 5'd24;
            8'h35: idx = 5'd25;  8'h1A: idx = 5'd26;
            8'h16: sym = "1!";   8'h1E: sym = "2@";   8'h26: sym = "3#";   8'h25: sym = "4$";
            8'h2E: sym = "5%";   8'h36: sym = "6^";   8'h3D: sym = "7&";   8'h3E: sym = "8*";
            8'h46: sym = "9(";   8'h45: sym = "0)";   8'h29: sym = "  ";   8'h4E: sym = "-_";
            8'h55: sym = "=+";   8'h41: sym = ",<";   8'h49: sym = ".>";   8'h4A: sym = "/?";
            8'h4C: sym = ";:";   8'h52: sym = "'\"";  8'h54: sym = "[{";   8'h5B: sym = "]}";
            8'h5D: sym = "\\|";  8'h0E: sym = "`~";
            8'h5A: cmd = LCD_NEWLINE;
            8'h66: cmd = LCD_BKSP;
            default: ;
        endcase
    end

    // Lowercase letters use their alphabet index; uppercase are RS=1 ASCII.
    assign lcd_code_o = idx != '0 ? (letter_upper_i ? {1'b1, 8'h40 | {3'b0, idx}} : {4'b0, idx}) :
                        sym != '0 ? {1'b1, symbol_upper_i ? sym[7:0] : sym[15:8]} : cmd;
    assign mapped_o = idx != '0 || sym != '0 || cmd != '0;
endmodule

// File: rtl/ps2_lcd_stream.sv
// ps2_lcd_stream: PS/2 set-2 byte stream to LCD code FIFO with shift/caps tracking and repeat suppression.
module ps2_lcd_stream
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter int REPEAT_SUPPRESS = 1,
    parameter int CAPS_ENABLE     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_valid_i,
    input  logic [7:0] scan_code_i,
    input  logic       lcd_ready_i,
    output logic       lcd_valid_o,
    output logic [8:0] lcd_code_o,
    output logic       caps_lock_o,
    output logic       shift_held_o,
    output logic       overflow_o,
    input  logic       overflow_clr_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    ps2_state_t    state_q, state_d;
    logic          caps_q, caps_held_q, lsh_q, rsh_q, ovf_q, ovf_d;
    logic [7:0]    last_q;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic [8:0]    lut_code, ext_code, push_code;
    logic          lut_mapped, take, pfx, mk, ext_mk, brk, is_shift, is_caps;
    logic          push_req, push, pop, full;

    ps2_lcd_lut u_lut (
        .scan_code_i   (scan_code_i),
        .letter_upper_i(shift_held_o ^ caps_q),
        .symbol_upper_i(shift_held_o),
        .lcd_code_o    (lut_code),
        .mapped_o      (lut_mapped)
    );

    always_comb begin
        take     = scan_valid_i && !is_ignored(scan_code_i);
        pfx      = scan_code_i == SC_BREAK || scan_code_i == SC_EXT;
        mk       = take && !pfx && state_q == IDLE;
        ext_mk   = take && !pfx && state_q == EXT;
        brk      = take && !pfx && state_q == BRK;
        is_shift = scan_code_i == SC_LSHIFT || scan_code_i == SC_RSHIFT;
        is_caps  = CAPS_ENABLE != 0 && scan_code_i == SC_CAPS;
        ext_code = scan_code_i == 8'h5A ? LCD_NEWLINE : scan_code_i == 8'h6B ? LCD_CUR_L :
                   scan_code_i == 8'h74 ? LCD_CUR_R : scan_code_i == 8'h71 ? LCD_BKSP : '0;
        push_req = (mk && !is_shift && scan_code_i != SC_CAPS && lut_mapped &&
                    !(REPEAT_SUPPRESS != 0 && scan_code_i == last_q)) || (ext_mk && ext_code != '0);
        push_code = ext_mk ? ext_code : lut_code;
        full     = cnt_q == CW'(FIFO_DEPTH);
        pop      = lcd_valid_o && lcd_ready_i;
        push     = push_req && (!full || pop);
        ovf_d    = (push_req && !push) ? 1'b1 : overflow_clr_i ? 1'b0 : ovf_q;
        state_d  = !take ? state_q :
                   state_q == IDLE ? (scan_code_i == SC_BREAK ? BRK : scan_code_i == SC_EXT ? EXT : IDLE) :
                   state_q == BRK  ? (scan_code_i == SC_BREAK ? BRK : scan_code_i == SC_EXT ? EXT_BRK : IDLE) :
                   state_q == EXT  ? (scan_code_i == SC_BREAK ? EXT_BRK : scan_code_i == SC_EXT ? EXT : IDLE) :
                   (scan_code_i == SC_BREAK ? EXT_BRK : IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            lsh_q       <= 1'b0;
            rsh_q       <= 1'b0;
            ovf_q       <= 1'b0;
            last_q      <= 8'h00;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            if (mk) begin
                if (scan_code_i == SC_LSHIFT) lsh_q <= 1'b1;
                if (scan_code_i == SC_RSHIFT) rsh_q <= 1'b1;
                if (is_caps) begin
                    caps_held_q <= 1'b1;
                    if (!caps_held_q) caps_q <= ~caps_q;
                end
                if (!is_shift && scan_code_i != SC_CAPS) last_q <= scan_code_i;
            end
            if (brk) begin
                if (scan_code_i == SC_LSHIFT) lsh_q <= 1'b0;
                if (scan_code_i == SC_RSHIFT) rsh_q <= 1'b0;
                if (scan_code_i == SC_CAPS) caps_held_q <= 1'b0;
                if (scan_code_i == last_q) last_q <= 8'h00;
            end
            if (push) begin
                mem_q[wr_q] <= push_code;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    assign lcd_valid_o  = cnt_q != '0;
    assign lcd_code_o   = lcd_valid_o ? mem_q[rd_q] : '0;
    assign caps_lock_o  = caps_q;
    assign shift_held_o = lsh_q | rsh_q;
    assign overflow_o   = ovf_q;
endmodule
